lfsr_range_gen: RTL and testbench

- Parametrised successor to the 4-bit mod-10 random generator.
- Contains a WIDTH-bit Fibonacci LFSR with a configurable tap mask, a loadable seed and zero-lockup recovery.
- Returns numbers uniformly distributed in [0, RANGE-1] through a req/valid handshake, using rejection sampling with a bounded retry count.
- Feeds game and display logic that needs unbiased digits or indices.

---
 rtl/rand_pkg.sv | 24 ++
 rtl/lfsr_core.sv | 26 ++
 rtl/lfsr_range_gen.sv | 107 ++++++++++
 tb/tb_lfsr_range_gen.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/rand_pkg.sv
// Shared definitions for the random-number blocks: draw FSM states,
// a constant clog2 helper and known-good Fibonacci tap masks per width.
package rand_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      DRAW = 1'b1
   } draw_state_t;

   localparam logic [3:0]  TAPS_W4  = 4'hC;
   localparam logic [7:0]  TAPS_W8  = 8'hB8;
   localparam logic [15:0] TAPS_W16 = 16'hB400;
   localparam logic [31:0] TAPS_W32 = 32'h80200003;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR register with step, seed load and zero-lockup guard.
// A zero seed is replaced by SEED so the register can never stick at 0.
module lfsr_core #(
   parameter int               WIDTH = 16,
   parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
   parameter logic [WIDTH-1:0] SEED  = 16'hFFFF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [WIDTH-1:0] seed,
   input  logic             step,
   output logic [WIDTH-1:0] state
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= SEED;
      end else if (load) begin
         state <= (seed == '0) ? SEED : seed;
      end else if (step) begin
         state <= {state[WIDTH-2:0], ^(state & TAPS)};
      end
   end

endmodule

// File: rtl/lfsr_range_gen.sv
// Uniform random numbers in [0, RANGE-1] via rejection sampling on an LFSR,
// with a req/valid handshake and a bounded-retry fallback path.
module lfsr_range_gen
   import rand_pkg::*;
#(
   parameter int               WIDTH     = 16,
   parameter logic [WIDTH-1:0] TAPS      = 16'hB400,
   parameter logic [WIDTH-1:0] SEED      = 16'hFFFF,
   parameter int               RANGE     = 10,
   parameter int               OUT_W     = 4,
   parameter int               MAX_TRIES = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             stop,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed,
   input  logic             req,
   output logic             busy,
   output logic             rand_valid,
   output logic [OUT_W-1:0] rand_num,
   output logic [WIDTH-1:0] lfsr_state
);

   localparam int CAND_W = clog2(RANGE);
   localparam int TRY_W  = clog2(MAX_TRIES + 1);
   localparam logic [CAND_W:0]  RANGE_EXT = (CAND_W + 1)'(RANGE);
   localparam logic [TRY_W-1:0] LAST_TRY  = TRY_W'(MAX_TRIES - 1);

   draw_state_t      state, state_next;
   logic [TRY_W-1:0] tries, tries_next;
   logic             busy_next, valid_next;
   logic [OUT_W-1:0] num_next;
   logic [CAND_W-1:0] candidate;
   logic             step;

   assign candidate = lfsr_state[CAND_W-1:0];
   assign step      = (state == DRAW) || !stop;

   lfsr_core #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS),
      .SEED  (SEED)
   ) u_lfsr (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (seed_load),
      .seed    (seed),
      .step    (step),
      .state   (lfsr_state)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         tries      <= '0;
         busy       <= 1'b0;
         rand_valid <= 1'b0;
         rand_num   <= '0;
      end else begin
         state      <= state_next;
         tries      <= tries_next;
         busy       <= busy_next;
         rand_valid <= valid_next;
         rand_num   <= num_next;
      end
   end

   // Out-of-range candidates retry; on the last allowed try the candidate is
   // folded down by RANGE, which lands in range because 2^CAND_W < 2*RANGE.
   always_comb begin
      state_next = state;
      tries_next = tries;
      busy_next  = busy;
      valid_next = 1'b0;
      num_next   = rand_num;
      case (state)
         IDLE: begin
            if (req) begin
               state_next = DRAW;
               tries_next = '0;
               busy_next  = 1'b1;
            end
         end
         DRAW: begin
            if ({1'b0, candidate} < RANGE_EXT) begin
               num_next   = OUT_W'(candidate);
               valid_next = 1'b1;
               state_next = IDLE;
               busy_next  = 1'b0;
            end else if (tries == LAST_TRY) begin
               num_next   = OUT_W'(CAND_W'({1'b0, candidate} - RANGE_EXT));
               valid_next = 1'b1;
               state_next = IDLE;
               busy_next  = 1'b0;
            end else begin
               tries_next = tries + TRY_W'(1);
            end
         end
         default: begin
            state_next = IDLE;
            busy_next  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_lfsr_range_gen.sv
// Scoreboard bench for lfsr_range_gen in the 4-bit mod-10 configuration,
// with a second instance limited to a single try to reach the fallback path.
module tb_lfsr_range_gen;

   logic       clk;
   logic       reset_n;
   logic       stop;
   logic       seed_load;
   logic [3:0] seed;
   logic       req;
   logic       req1;
   logic       busy0, valid0, busy1, valid1;
   logic [3:0] num0, num1, lfsr0, lfsr1;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int lastValidCyc = -100;
   int freeValids   = 0;
   bit freeMode     = 0;
   logic [3:0] expQ0[$];
   logic [3:0] expQ1[$];

   lfsr_range_gen #(
      .WIDTH(4), .TAPS(4'hC), .SEED(4'hF), .RANGE(10), .OUT_W(4), .MAX_TRIES(8)
   ) dut0 (
      .clk(clk), .reset_n(reset_n), .stop(stop), .seed_load(seed_load),
      .seed(seed), .req(req), .busy(busy0), .rand_valid(valid0),
      .rand_num(num0), .lfsr_state(lfsr0)
   );

   lfsr_range_gen #(
      .WIDTH(4), .TAPS(4'hC), .SEED(4'hF), .RANGE(10), .OUT_W(4), .MAX_TRIES(1)
   ) dut1 (
      .clk(clk), .reset_n(reset_n), .stop(1'b1), .seed_load(1'b0),
      .seed(4'h0), .req(req1), .busy(busy1), .rand_valid(valid1),
      .rand_num(num1), .lfsr_state(lfsr1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Scoreboard monitor for the main instance; in free mode only range and spacing are known.
   always @(negedge clk) begin
      cyc++;
      if (valid0) begin
         if (freeMode) begin
            freeValids++;
            checkOutput("free_range", int'(num0 < 4'd10), 1);
            checkOutput("free_gap_ok", int'((cyc - lastValidCyc) >= 2), 1);
         end else if (expQ0.size() == 0) begin
            checkOutput("unexpected_valid0", 1, 0);
         end else begin
            checkOutput("rand_num0", int'(num0), int'(expQ0.pop_front()));
         end
         lastValidCyc = cyc;
      end
   end

   always @(negedge clk) begin
      if (valid1) begin
         if (expQ1.size() == 0) checkOutput("unexpected_valid1", 1, 0);
         else checkOutput("rand_num1", int'(num1), int'(expQ1.pop_front()));
      end
   end

   task automatic applyReset();
      @(negedge clk);
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic applyStimulus(input bit useB, input logic [3:0] expected);
      @(negedge clk);
      if (useB) begin
         req1 = 1'b1;
         expQ1.push_back(expected);
      end else begin
         req = 1'b1;
         expQ0.push_back(expected);
      end
   endtask

   task automatic waitValid(input bit useB, output int edges, output int busyCnt);
      edges   = -1;
      busyCnt = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         req       = 1'b0;
         req1      = 1'b0;
         seed_load = 1'b0;
         if (useB ? busy1 : busy0) busyCnt++;
         if (useB ? valid1 : valid0) begin
            edges = i - 1;
            return;
         end
      end
   endtask

   logic [3:0] freeSeq [16] = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h1, 4'h2, 4'h4, 4'h9,
                                4'h3, 4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7, 4'hF};

   initial begin
      int edges, busyCnt;
      reset_n = 1'b0; stop = 1'b1; seed_load = 1'b0; seed = 4'h0;
      req = 1'b0; req1 = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset_busy", int'(busy0), 0);
      checkOutput("reset_valid", int'(valid0), 0);
      checkOutput("reset_num", int'(num0), 0);
      checkOutput("reset_lfsr", int'(lfsr0), 15);
      reset_n = 1'b1;

      // Frozen LFSR: F, E, C rejected, 8 accepted on the 4th draw edge.
      applyStimulus(0, 4'h8);
      waitValid(0, edges, busyCnt);
      checkOutput("draw_edges_8", edges, 4);
      checkOutput("busy_cycles_8", busyCnt, 4);

      // Free-running sequence from reset, period 15.
      @(negedge clk);
      reset_n = 1'b0;
      stop = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 16; i++) begin
         checkOutput($sformatf("free_lfsr_%0d", i), int'(lfsr0), int'(freeSeq[i]));
         @(negedge clk);
      end
      stop = 1'b1;

      // Single-try instance takes the fallback: 15 - 10 = 5.
      applyReset();
      applyStimulus(1, 4'h5);
      waitValid(1, edges, busyCnt);
      checkOutput("fallback_edges", edges, 1);

      // Seed loading, including the zero-seed guard.
      @(negedge clk);
      seed_load = 1'b1; seed = 4'h5;
      @(negedge clk);
      checkOutput("seed_load_5", int'(lfsr0), 5);
      seed = 4'h0;
      @(negedge clk);
      checkOutput("seed_load_zero", int'(lfsr0), 15);
      seed = 4'h3;
      applyStimulus(0, 4'h3);
      waitValid(0, edges, busyCnt);
      checkOutput("seed3_edges", edges, 1);

      // Asynchronous reset during the second draw cycle aborts silently.
      applyReset();
      @(negedge clk);
      req = 1'b1;
      repeat (2) @(negedge clk);
      req = 1'b0;
      reset_n = 1'b0;
      #1;
      checkOutput("abort_busy", int'(busy0), 0);
      checkOutput("abort_valid", int'(valid0), 0);
      checkOutput("abort_lfsr", int'(lfsr0), 15);
      @(negedge clk);
      reset_n = 1'b1;
      applyStimulus(0, 4'h8);
      waitValid(0, edges, busyCnt);
      checkOutput("after_abort_edges", edges, 4);

      // Held request with random stop and seed loads.
      @(negedge clk);
      freeMode = 1'b1;
      req = 1'b1;
      for (int i = 0; i < 100; i++) begin
         stop      = 1'($urandom_range(0, 1));
         seed_load = ($urandom_range(0, 7) == 0);
         seed      = 4'($urandom_range(0, 15));
         @(negedge clk);
      end
      req = 1'b0; seed_load = 1'b0; stop = 1'b1;
      repeat (15) @(negedge clk);
      freeMode = 1'b0;
      checkOutput("free_any_valid", int'(freeValids > 10), 1);

      checkOutput("queue0_drained", expQ0.size(), 0);
      checkOutput("queue1_drained", expQ1.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
